// File: rtl/prim_fetch_sched_if.sv
// Descriptor handshake between the fetch sequencer and the rasterizer.
//   desc_valid : descriptor available (master drives)
//   desc_ready : rasterizer accepts it (slave drives)
//   desc_data  : nine packed words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   desc_index : 0-based index of the presented descriptor
interface prim_fetch_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    desc_valid;
  logic                    desc_ready;
  logic [9*DATA_WIDTH-1:0] desc_data;
  logic [7:0]              desc_index;

  modport master (output desc_valid, output desc_data, output desc_index, input desc_ready);
  modport slave  (input desc_valid, input desc_data, input desc_index, output desc_ready);
endinterface

// File: rtl/prim_fetch_sched.sv
// prim_fetch_sched: walks the descriptor RAM in STRIDE-word slots, latches each
// nine-word primitive descriptor and presents it over a valid/ready handshake.
// Also owns the RAM write port, admitting host writes only while idle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start/base_addr/prim_cnt run request, sampled in IDLE
//   busy, done, err          status (err is sticky overrun flag)
//   ram_read_addr/ram_rd_bus asynchronous nine-port RAM read
//   desc                     descriptor handshake (master modport)
//   host_we/addr/data        host loader write request; host_stall when refused
//   ram_we/wr_addr/wr_data   RAM write port
//
// Optional: define END_MARKER_EN to end a run early when word0's top byte is 8'hFF.
//
// state   | meaning
// IDLE    | waiting for start, host writes admitted
// CHECK   | verify the current slot fits inside the RAM
// FETCH   | latch the asynchronous RAM read into the descriptor register
// PRESENT | descriptor held until the rasterizer accepts it
// DONE    | one-cycle done pulse, then back to IDLE
module prim_fetch_sched #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int STRIDE     = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]              prim_count,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   ram_read_addr,
  input  logic [9*DATA_WIDTH-1:0] ram_rd_bus,
  prim_fetch_sched_if.master      desc,
  input  logic                    host_we,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [DATA_WIDTH-1:0]   host_data,
  output logic                    host_stall,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_PRESENT, S_DONE} state_t;

  localparam logic [ADDR_WIDTH+1:0] SLOT_SPAN = (ADDR_WIDTH+2)'(STRIDE - 1);
  localparam logic [ADDR_WIDTH:0]   SLOT_STEP = (ADDR_WIDTH+1)'(STRIDE);

  state_t                state;
  // Top bit keeps the carry of a stride advance so a wrapped address can
  // never pass CHECK and fetch from the bottom of the RAM.
  logic [ADDR_WIDTH:0]   addr_q;
  logic [7:0]            idx_q;
  logic [7:0]            count_q;
  logic [ADDR_WIDTH+1:0] slot_end;
  logic                  overrun;
  logic                  end_marker;

  assign slot_end      = {1'b0, addr_q} + SLOT_SPAN;
  assign overrun       = |slot_end[ADDR_WIDTH+1:ADDR_WIDTH];
  assign ram_read_addr = addr_q[ADDR_WIDTH-1:0];

`ifdef END_MARKER_EN
  assign end_marker = (ram_rd_bus[DATA_WIDTH-1 -: 8] == 8'hFF);
`else
  assign end_marker = 1'b0;
`endif

  assign ram_we      = host_we & ~busy;
  assign host_stall  = host_we & busy;
  assign ram_wr_addr = host_addr;
  assign ram_wr_data = host_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      addr_q          <= '0;
      idx_q           <= '0;
      count_q         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      desc.desc_valid <= 1'b0;
      desc.desc_data  <= '0;
      desc.desc_index <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            err     <= 1'b0;
            count_q <= prim_count;
            if (prim_count == 8'd0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              addr_q <= {1'b0, base_addr};
              idx_q  <= '0;
              state  <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (overrun) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (end_marker) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            desc.desc_data  <= ram_rd_bus;
            desc.desc_valid <= 1'b1;
            desc.desc_index <= idx_q;
            state           <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (desc.desc_ready) begin
            desc.desc_valid <= 1'b0;
            if (idx_q == count_q - 8'd1) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx_q  <= idx_q + 8'd1;
              addr_q <= addr_q + SLOT_STEP;
              state  <= S_CHECK;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/prim_fetch_sched.md
Name: prim_fetch_sched

Overview:
Sequencer for the primitive memory in the line/triangle pipeline.
- Walks the 9-word-read RAM in fixed-stride descriptor slots.
- Latches each 9-word primitive descriptor and hands it to the rasterizer over a valid/ready handshake.
- Owns the RAM write port and admits host loader writes only while no fetch run is active.

Parameters:
ADDR_WIDTH, 8, RAM address width; also width of base_addr and ram_read_addr.
DATA_WIDTH, 32, RAM word width.
STRIDE, 9, words per descriptor slot; legal range 1..9.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  start pulse; sampled only in IDLE.
base_addr  in  ADDR_WIDTH  address of first descriptor; sampled with start.
prim_count  in  8  number of descriptors to fetch; sampled with start.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse at end of a run.
err  out  1  sticky overrun flag; cleared by the next accepted start or by rst.
ram_read_addr  out  ADDR_WIDTH  registered RAM read address.
ram_rd_bus  in  9*DATA_WIDTH  RAM read ports 1..9; word k (0..8) at bits [k*DATA_WIDTH +: DATA_WIDTH].
desc_valid  out  1  descriptor available.
desc_ready  in  1  rasterizer accepts the descriptor.
desc_data  out  9*DATA_WIDTH  latched descriptor, same packing as ram_rd_bus.
desc_index  out  8  index of the presented descriptor, 0-based.
host_we  in  1  host write request.
host_addr  in  ADDR_WIDTH  host write address.
host_data  in  DATA_WIDTH  host write data.
host_stall  out  1  combinational; high when host_we is set while busy; the write is not performed and the host holds its request.
ram_we, ram_wr_addr, ram_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port.

Behaviour:
Reset values:
- All outputs 0; state IDLE.
- rst mid-run abandons the run; no done pulse.

Host write path:
- ram_we = host_we & ~busy, combinational.
- ram_wr_addr = host_addr; ram_wr_data = host_data.
- A host write in the same cycle as start lands on that edge. Its data is therefore visible to the first FETCH.

State machine:
- IDLE: on start with prim_count==0, go to DONE. On start with prim_count!=0: load ram_read_addr=base_addr, index=0, clear err, go to CHECK.
- CHECK: if ram_read_addr + STRIDE - 1 > 2^ADDR_WIDTH - 1, the slot overruns the RAM. Set err and go to DONE. Otherwise go to FETCH.
- FETCH: RAM read is asynchronous. At the end of this cycle latch ram_rd_bus into desc_data. Set desc_valid=1 and desc_index=index, then go to PRESENT.
- PRESENT: hold desc_valid, desc_data and desc_index stable until desc_ready. On the desc_valid & desc_ready edge, clear desc_valid.
  - If index == prim_count-1, go to DONE.
  - Otherwise index++, ram_read_addr += STRIDE, go to CHECK.
- DONE: done=1 for exactly one cycle, then go to IDLE.

Timing and arithmetic:
- Latency: start to first desc_valid is 3 cycles (CHECK, FETCH, then PRESENT).
- Back-to-back throughput is one descriptor per 3 cycles with desc_ready held high.
- start while busy is ignored.
- The address adder is ADDR_WIDTH+1 bits wide for the overrun compare. No wrap-around fetch is ever issued.

Optional Feature:
Macro END_MARKER_EN.
- Defined: in FETCH, if word0[DATA_WIDTH-1:DATA_WIDTH-8]==8'hFF, the run terminates early. No descriptor is presented, the FSM goes to DONE, and err is unchanged.
- Undefined: word0 is never inspected; all prim_count descriptors are presented.

Test Plan:
- Preload slots at 0 and 9 via the host, then start with base=0, count=2 and desc_ready=1 -> two descriptors, desc_index 0 then 1, data matching the preload; first desc_valid 3 cycles after start; done pulses once; busy drops the cycle after done.
- desc_ready held low for 5 cycles in PRESENT -> desc_valid, desc_data and desc_index remain stable; there is no address advance.
- base=250 (ADDR_WIDTH=8), count=1 -> CHECK detects 250+8>255; err=1, no desc_valid, done pulses; err is cleared by the next start.
- host_we during a run with host_addr=5 -> host_stall=1 and ram_we=0 while busy; the write lands the cycle after busy falls.
- start with count=0 -> done pulses 1 cycle later and no RAM read occurs. Separately, rst asserted in PRESENT -> all outputs 0 next cycle with no done pulse.
- With END_MARKER_EN defined, slot 1 word0 = 0xFF000000, count=3 -> exactly one descriptor is presented, then done.
